// File: rtl/i2s_rx.sv
// ----------------------------------------------------------------------------
// i2s_rx
// I2S receiver acting as bus master. Generates the bit clock and word select
// from MasterCLK, deserialises Philips-format stereo 16-bit samples from an
// ADC, and hands complete {Left,Right} frames to a consumer through a small
// show-ahead FIFO with a valid/ready handshake.
//
// Parameters
//   CLK_DIV     MasterCLK cycles per I2S_CLK half-period (>= 2)
//   FIFO_DEPTH  frames buffered (power of 2, >= 2)
//
// Ports
//   MasterCLK    in   system clock, all logic on the rising edge
//   Reset        in   asynchronous, active-low reset
//   Enable       in   1 runs the I2S clocks and capture, 0 idles them
//   I2S_DATA     in   serial data from the ADC (changes on I2S_CLK fall)
//   I2S_CLK      out  bit clock to the ADC
//   I2S_WS       out  word select, 0 = left, 1 = right
//   OutputData   out  FIFO head, {Left[15:0], Right[15:0]}
//   OutputValid  out  FIFO not empty
//   OutputReady  in   consumer takes the head when valid & ready
//   Overflow     out  sticky, a completed frame was dropped on a full FIFO
// ----------------------------------------------------------------------------
module i2s_rx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        MasterCLK,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        I2S_DATA,
    output logic        I2S_CLK,
    output logic        I2S_WS,
    output logic [31:0] OutputData,
    output logic        OutputValid,
    input  logic        OutputReady,
    output logic        Overflow
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot;
    logic             primed;
    logic             term;
    logic             sck_rise;
    logic             sck_fall;
    logic [31:0]      frame;
    logic             push;
    logic             pop;
    logic             full;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW-1:0]    rd_next_idx;
    logic [31:0]      mem [FIFO_DEPTH];

    // Only 31 bits are stored: the 32nd (right LSB) is taken live from
    // I2S_DATA on the same edge that completes the frame.
    logic [30:0]      shift;

    assign term     = Enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sck_rise = term && !I2S_CLK;
    assign sck_fall = term && I2S_CLK;
    assign frame    = {shift, I2S_DATA};

    // The very first slot-0 rise after enable closes a partial frame; primed
    // marks that it has gone by, so only later slot-0 rises push.
    assign push = sck_rise && (slot == 5'd0) && primed;

    assign count       = wr_ptr - rd_ptr;
    assign OutputValid = (count != '0);
    assign full        = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop         = OutputValid && OutputReady;
    assign rd_next_idx = rd_ptr[AW-1:0] + AW'(1);

    // Bit clock, word select and deserialiser. Dropping Enable clears all of
    // it on the next edge so a re-enable starts cleanly at slot 0.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            div_cnt <= '0;
            I2S_CLK <= 1'b0;
            I2S_WS  <= 1'b0;
            slot    <= '0;
            shift   <= '0;
            primed  <= 1'b0;
        end else if (!Enable) begin
            div_cnt <= '0;
            I2S_CLK <= 1'b0;
            I2S_WS  <= 1'b0;
            slot    <= '0;
            shift   <= '0;
            primed  <= 1'b0;
        end else begin
            div_cnt <= term ? '0 : div_cnt + DIV_W'(1);
            if (sck_rise) begin
                I2S_CLK <= 1'b1;
                shift   <= frame[30:0];
                if (slot == 5'd0)
                    primed <= 1'b1;
            end
            if (sck_fall) begin
                I2S_CLK <= 1'b0;
                slot    <= slot + 5'd1;
                // WS reflects the slot being entered: high for 16..31.
                I2S_WS  <= (slot >= 5'd15) && (slot != 5'd31);
            end
        end
    end

    // Storage is written only when the push is accepted; a full FIFO with a
    // simultaneous pop frees the slot being written.
    always_ff @(posedge MasterCLK) begin
        if (push && (!full || pop))
            mem[wr_ptr[AW-1:0]] <= frame;
    end

    // Pointers, registered head and sticky overflow. OutputData is a
    // register rather than a mem read so it holds its last value when empty.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            OutputData <= '0;
            Overflow   <= 1'b0;
        end else begin
            if (push && (!full || pop))
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW + 1)'(1);

            if (pop) begin
                if (count > (AW + 1)'(1))
                    OutputData <= mem[rd_next_idx];
                else if (push)
                    OutputData <= frame;
            end else if (!OutputValid && push) begin
                OutputData <= frame;
            end

            if (!Enable)
                Overflow <= 1'b0;
            else if (push && full && !pop)
                Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// ----------------------------------------------------------------------------
// tb_i2s_rx
// Self-checking bench for i2s_rx. An ADC model drives random (or fixed)
// stereo frames in Philips format off the generated bit clock; a queue-based
// FIFO model predicts OutputValid, OutputData and Overflow cycle by cycle.
// ----------------------------------------------------------------------------
module tb_i2s_rx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int WS_PERIOD  = 64 * CLK_DIV;

    logic        MasterCLK = 1'b0;
    logic        Reset     = 1'b0;
    logic        Enable    = 1'b0;
    logic        I2S_DATA  = 1'b0;
    logic        OutputReady = 1'b0;
    logic        I2S_CLK;
    logic        I2S_WS;
    logic [31:0] OutputData;
    logic        OutputValid;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    // ADC model state
    int          tb_slot = 0;
    bit          armed = 1'b0;
    bit          fixed_mode = 1'b1;
    logic [31:0] cur = '0;

    // Clock timing bookkeeping
    int cyc = 0;
    int en_cyc = 0;
    int last_rise = 0;
    bit rise_seen = 1'b0;

    // FIFO model
    logic [31:0] model[$];
    logic [31:0] hold_m = '0;
    logic [31:0] push_frame = '0;
    bit          push_pending = 1'b0;
    bit          pop_next = 1'b0;
    bit          ovf_m = 1'b0;
    bit          en_prev = 1'b0;
    int          popped = 0;

    i2s_rx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .MasterCLK  (MasterCLK),
        .Reset      (Reset),
        .Enable     (Enable),
        .I2S_DATA   (I2S_DATA),
        .I2S_CLK    (I2S_CLK),
        .I2S_WS     (I2S_WS),
        .OutputData (OutputData),
        .OutputValid(OutputValid),
        .OutputReady(OutputReady),
        .Overflow   (Overflow)
    );

    always #5 MasterCLK = ~MasterCLK;

    always @(posedge MasterCLK) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Inputs change just after a clock edge so they are stable at the next.
    task automatic apply_stimulus(input logic en, input logic rdy);
        @(posedge MasterCLK);
        #1;
        if (en && !Enable)
            en_cyc = cyc;
        Enable      = en;
        OutputReady = rdy;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge MasterCLK);
        #1;
    endtask

    task automatic wait_slot(input int target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge MasterCLK);
            if (tb_slot == target)
                hit = 1'b1;
        end
        #1;
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL wait_slot actual=timeout required=slot %0d", target);
        end
    endtask

    task automatic wait_model_size(input int target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge MasterCLK);
            if (model.size() == target)
                hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL wait_buffered actual=timeout required=%0d entries", target);
        end
    endtask

    // Disable or reset loses any frame in progress and restarts at slot 0.
    always @(negedge Enable or negedge Reset) begin
        tb_slot   = 0;
        armed     = 1'b0;
        rise_seen = 1'b0;
    end

    // ADC: a new frame starts at slot 1; its LSB goes out in the following
    // slot 0 (one-bit Philips delay).
    always @(negedge I2S_CLK) begin
        if (Reset && Enable) begin
            if (rise_seen)
                check_output("sck_high_time", 32'(cyc - last_rise), 32'(CLK_DIV));
            tb_slot = (tb_slot + 1) % 32;
            if (tb_slot == 1) begin
                cur   = fixed_mode ? 32'hA55A1234 : $urandom;
                armed = 1'b1;
            end
            I2S_DATA = (tb_slot == 0) ? cur[0] : cur[32 - tb_slot];
        end
    end

    always @(posedge I2S_CLK) begin
        if (Reset && Enable) begin
            if (rise_seen)
                check_output("sck_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
            else
                check_output("sck_first_rise", 32'(cyc - en_cyc), 32'(CLK_DIV));
            rise_seen = 1'b1;
            last_rise = cyc;
            if (tb_slot == 0 && armed) begin
                push_pending = 1'b1;
                push_frame   = cur;
            end
        end
    end

    // Monitor: replays the handshake and completed frames of the last edge
    // onto the FIFO model, then compares the DUT outputs with it.
    always @(negedge MasterCLK) begin
        if (!Reset) begin
            model.delete();
            hold_m       = '0;
            ovf_m        = 1'b0;
            pop_next     = 1'b0;
            push_pending = 1'b0;
            check_output("reset_valid", 32'(OutputValid), 32'd0);
            check_output("reset_data", OutputData, 32'd0);
            check_output("reset_overflow", 32'(Overflow), 32'd0);
            check_output("reset_sck", 32'(I2S_CLK), 32'd0);
            check_output("reset_ws", 32'(I2S_WS), 32'd0);
        end else begin
            if (pop_next) begin
                void'(model.pop_front());
                popped++;
            end
            if (push_pending) begin
                push_pending = 1'b0;
                if (model.size() < FIFO_DEPTH)
                    model.push_back(push_frame);
                else
                    ovf_m = 1'b1;
            end
            if (!en_prev)
                ovf_m = 1'b0;
            if (model.size() > 0)
                hold_m = model[0];
            check_output("valid", 32'(OutputValid), 32'(model.size() > 0));
            check_output("data", OutputData, hold_m);
            check_output("overflow", 32'(Overflow), 32'(ovf_m));
            if (en_prev && Enable)
                check_output("ws_slot", 32'(I2S_WS), 32'(tb_slot >= 16));
            if (!en_prev && !Enable) begin
                check_output("idle_sck", 32'(I2S_CLK), 32'd0);
                check_output("idle_ws", 32'(I2S_WS), 32'd0);
            end
            pop_next = (model.size() > 0) && OutputReady;
        end
        en_prev = Enable;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;

        // Reset held with Enable high: everything stays quiet.
        Reset       = 1'b0;
        Enable      = 1'b1;
        OutputReady = 1'b0;
        wait_cycles(6);
        check_output("held_reset_sck", 32'(I2S_CLK), 32'd0);
        check_output("held_reset_valid", 32'(OutputValid), 32'd0);

        // Fixed pattern, consumer always ready: exactly five frames appear in
        // 5 WS periods because the first partial period is discarded.
        $display("[TB] fixed pattern capture");
        fixed_mode = 1'b1;
        @(posedge MasterCLK);
        #1;
        Reset       = 1'b1;
        en_cyc      = cyc;
        OutputReady = 1'b1;
        base        = popped;
        wait_cycles(WS_PERIOD + 3);
        check_output("first_frame_not_early", 32'(popped - base), 32'd0);
        wait_cycles(5 * WS_PERIOD - WS_PERIOD - 3 + 20);
        check_output("fixed_frames", 32'(popped - base), 32'd5);
        check_output("fixed_hold_data", OutputData, 32'hA55A1234);

        // Consumer stalls for six frames: four buffered, the fifth overflows.
        $display("[TB] stall and overflow");
        fixed_mode = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        wait_cycles(6 * WS_PERIOD - 1);
        check_output("stall_overflow", 32'(Overflow), 32'd1);
        check_output("stall_valid", 32'(OutputValid), 32'd1);
        base = popped;
        apply_stimulus(1'b1, 1'b1);
        wait_cycles(8);
        check_output("drain_count", 32'(popped - base), 32'd4);
        check_output("drain_empty", 32'(OutputValid), 32'd0);

        // Random back-pressure over several frames.
        $display("[TB] random ready");
        for (int i = 0; i < 4 * WS_PERIOD; i++)
            apply_stimulus(1'b1, 1'($urandom_range(0, 1)));

        // Disable mid-frame at slot 20, then resume.
        $display("[TB] disable mid-frame");
        apply_stimulus(1'b1, 1'b1);
        wait_slot(20, 2 * WS_PERIOD);
        apply_stimulus(1'b0, 1'b1);
        wait_cycles(30);
        check_output("disabled_overflow", 32'(Overflow), 32'd0);
        check_output("disabled_sck", 32'(I2S_CLK), 32'd0);
        base = popped;
        apply_stimulus(1'b1, 1'b1);
        wait_cycles(3 * WS_PERIOD + 10);
        check_output("resume_frames", 32'(popped - base), 32'd3);

        // Reset with two frames buffered.
        $display("[TB] reset mid-frame");
        apply_stimulus(1'b1, 1'b0);
        wait_model_size(2, 3 * WS_PERIOD);
        @(negedge MasterCLK);
        #2;
        Reset = 1'b0;
        #1;
        check_output("async_reset_valid", 32'(OutputValid), 32'd0);
        check_output("async_reset_data", OutputData, 32'd0);
        wait_cycles(3);
        @(posedge MasterCLK);
        #1;
        Reset       = 1'b1;
        en_cyc      = cyc;
        OutputReady = 1'b1;
        base        = popped;
        wait_cycles(WS_PERIOD - 1);
        check_output("post_reset_none", 32'(popped - base), 32'd0);
        wait_cycles(10);
        check_output("post_reset_first", 32'(popped - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
